// File: rtl/mdio_pkg.sv
// ---------------------------------------------------------------------------
// mdio_pkg
// Shared constants and state encoding for the MDIO station-side controller.
//   OP_WRITE / OP_READ / ST_CODE : clause-22 field codes
//   FRAME_LEN                    : bits in one management frame
//   TA_BIT                       : first turnaround bit (line released on reads)
//   DATA_BIT                     : first data bit (read sampling starts here)
//   mdio_state_t                 : controller FSM states
// ---------------------------------------------------------------------------
package mdio_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST_CODE  = 2'b01;

  localparam int FRAME_LEN = 32;
  localparam int TA_BIT    = 14;
  localparam int DATA_BIT  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_DRIVE = 2'd2,
    S_READ  = 2'd3
  } mdio_state_t;

endpackage

// File: rtl/mdio_clkgen.sv
// ---------------------------------------------------------------------------
// mdio_clkgen
// MDC divider / phase counter. While enabled, walks a 2*DIV_HALF-cycle
// period and flags the edges on which MDC must fall and rise.
//   i_clk        : system clock
//   i_rst        : synchronous active-high reset
//   i_en         : run the divider (controller busy); low parks the phase at 0
//   o_fall_tick  : this edge starts a bit slot (MDC -> 0, data updates)
//   o_rise_tick  : this edge starts the high phase (MDC -> 1)
//   o_end_high   : fall tick that also closes a previous high phase
// ---------------------------------------------------------------------------
module mdio_clkgen #(
  parameter int DIV_HALF = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_fall_tick,
  output logic o_rise_tick,
  output logic o_end_high
);

  localparam int              CW     = $clog2(2 * DIV_HALF);
  localparam logic [CW-1:0]   C_LAST = CW'(2 * DIV_HALF - 1);
  localparam logic [CW-1:0]   C_RISE = CW'(DIV_HALF);

  logic [CW-1:0] r_cnt;
  logic          r_started;

  // Phase 0 of every period is the slot start; the very first one after
  // enable has no preceding high phase, hence r_started.
  assign o_fall_tick = i_en && (r_cnt == '0);
  assign o_rise_tick = i_en && (r_cnt == C_RISE);
  assign o_end_high  = o_fall_tick && r_started;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt     <= '0;
      r_started <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
      if (o_fall_tick) r_started <= 1'b1;
    end
  end

endmodule

// File: rtl/mdio_controller.sv
// ---------------------------------------------------------------------------
// mdio_controller
// MDIO station transmitter: serializes a clause-22 frame MSB-first, optional
// preamble, and for reads releases the line at turnaround and shifts in 16
// data bits from MDIO_IN.
//   CLK, reset  : system clock, synchronous active-high reset
//   MDC_START   : start request, honoured only in IDLE
//   T_DATA      : {ST,OP,PHYAD,REGAD,TA,DATA}, latched at start
//   MDIO_IN     : serial read data from the PHY side
//   MDC         : management clock (2*DIV_HALF CLK period)
//   MDIO_OUT/OE : serial data and drive enable towards the PHY side
//   RD_DATA     : last completed read, DATA_RDY pulses one CLK on update
//   BUSY        : frame in progress
// ---------------------------------------------------------------------------
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int DIV_HALF = 1,
  parameter int PRE_LEN  = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MDC_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  // Slot indices counted from the first preamble slot.
  localparam logic [6:0] L_PRE   = 7'(PRE_LEN);
  localparam logic [6:0] L_TOTAL = 7'(PRE_LEN + FRAME_LEN);
  localparam logic [6:0] L_TA    = 7'(PRE_LEN + TA_BIT);
  localparam logic [6:0] L_DATA  = 7'(PRE_LEN + DATA_BIT);

  mdio_state_t r_state, w_state_nxt;
  logic [31:0] r_frame;
  logic        r_is_read;
  logic [6:0]  r_slot;
  logic [14:0] r_rx;
  logic        r_mdc, r_out, r_oe, r_rdy, r_busy;
  logic [15:0] r_rd_data;

  logic w_fall, w_rise, w_end_high;
  logic w_start, w_last, w_sample;

  mdio_clkgen #(.DIV_HALF(DIV_HALF)) u_clkgen (
    .i_clk       (CLK),
    .i_rst       (reset),
    .i_en        (r_busy),
    .o_fall_tick (w_fall),
    .o_rise_tick (w_rise),
    .o_end_high  (w_end_high)
  );

  // r_slot counts slots already begun, so on a fall tick it is the index of
  // the slot about to start; reaching L_TOTAL means the last slot just ended.
  assign w_start  = (r_state == S_IDLE) && MDC_START;
  assign w_last   = w_end_high && (r_slot == L_TOTAL);
  assign w_sample = w_end_high && r_is_read && (r_slot > L_DATA);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (MDC_START) w_state_nxt = (PRE_LEN > 0) ? S_PRE : S_DRIVE;
      S_PRE:   if (w_fall && (r_slot == L_PRE)) w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (w_last)                                     w_state_nxt = S_IDLE;
        else if (w_fall && r_is_read && r_slot == L_TA) w_state_nxt = S_READ;
      end
      S_READ:  if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_is_read <= 1'b0;
      r_slot    <= '0;
      r_rx      <= '0;
      r_mdc     <= 1'b0;
      r_out     <= 1'b0;
      r_oe      <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b0;

      if (w_rise)      r_mdc <= 1'b1;
      else if (w_fall) r_mdc <= 1'b0;

      if (w_start) begin
        r_frame   <= T_DATA;
        r_is_read <= (T_DATA[29:28] == OP_READ);
        r_busy    <= 1'b1;
        r_slot    <= '0;
      end else if (w_last) begin
        r_busy <= 1'b0;
        r_oe   <= 1'b0;
        r_out  <= 1'b0;
        r_slot <= '0;
        if (r_is_read) begin
          r_rd_data <= {r_rx, MDIO_IN};
          r_rdy     <= 1'b1;
        end
      end else if (w_fall) begin
        r_slot <= r_slot + 7'd1;
        if (r_state == S_PRE && r_slot != L_PRE) begin
          r_out <= 1'b1;
          r_oe  <= 1'b1;
        end else if (r_is_read && r_slot >= L_TA) begin
          // Turnaround and data phase of a read: line belongs to the PHY.
          r_out <= 1'b0;
          r_oe  <= 1'b0;
        end else begin
          r_out   <= r_frame[31];
          r_oe    <= 1'b1;
          r_frame <= {r_frame[30:0], 1'b0};
        end
        if (w_sample) r_rx <= {r_rx[13:0], MDIO_IN};
      end
    end
  end

  assign MDC      = r_mdc;
  assign MDIO_OUT = r_out;
  assign MDIO_OE  = r_oe;
  assign RD_DATA  = r_rd_data;
  assign DATA_RDY = r_rdy;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_mdio_controller.sv
module tb_mdio_controller;

  localparam int F_BUSY = 0, F_MDC = 1, F_OE = 2, F_OUT = 3, F_RDY = 4,
                 F_RD = 5, F_CAP = 6, F_CAPN = 7, F_PER = 8, F_RDYCNT = 9;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        start_s [2];
  logic        mdin_s  [2];
  logic [31:0] td_s    [2];
  logic        mdc_w   [2];
  logic        out_w   [2];
  logic        oe_w    [2];
  logic        rdy_w   [2];
  logic        busy_w  [2];
  logic [15:0] rd_w    [2];

  mdio_controller #(.DIV_HALF(1), .PRE_LEN(0)) dut_a (
    .CLK(clk), .reset(rst_s[0]), .MDC_START(start_s[0]), .T_DATA(td_s[0]),
    .MDIO_IN(mdin_s[0]), .MDC(mdc_w[0]), .MDIO_OUT(out_w[0]), .MDIO_OE(oe_w[0]),
    .RD_DATA(rd_w[0]), .DATA_RDY(rdy_w[0]), .BUSY(busy_w[0]));

  mdio_controller #(.DIV_HALF(2), .PRE_LEN(32)) dut_b (
    .CLK(clk), .reset(rst_s[1]), .MDC_START(start_s[1]), .T_DATA(td_s[1]),
    .MDIO_IN(mdin_s[1]), .MDC(mdc_w[1]), .MDIO_OUT(out_w[1]), .MDIO_OE(oe_w[1]),
    .RD_DATA(rd_w[1]), .DATA_RDY(rdy_w[1]), .BUSY(busy_w[1]));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Requests from the stimulus process (written only by the initial block).
  int          kp [2] = '{0, 0};
  int          req_id [2] = '{0, 0};
  logic [31:0] fp [2];
  logic [15:0] rp [2];
  int          rst_e [2] = '{-1, -1};

  // Model state (written only by the compare process).
  int          done_id [2] = '{0, 0};
  int          kk [2] = '{-1, -1};
  logic [31:0] ff [2] = '{32'h0, 32'h0};
  logic [15:0] rr [2] = '{16'h0, 16'h0};
  logic [15:0] exp_rd [2] = '{16'h0, 16'h0};
  logic [63:0] cap [2] = '{64'h0, 64'h0};
  int          capn [2] = '{0, 0};
  int          r1 [2] = '{-1, -1};
  int          r2 [2] = '{-1, -1};
  int          rdycnt [2] = '{0, 0};
  logic        mdc_prev [2] = '{1'b0, 1'b0};

  // Hand-computed literal expectations, checked at a given edge.
  int          lit_n = 0;
  int          lit_e [64];
  int          lit_i [64];
  int          lit_f [64];
  logic [63:0] lit_v [64];
  string       lit_nm [64];

  function automatic int dv(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int pv(input int i);
    return (i == 0) ? 0 : 32;
  endfunction

  // Outputs observed after edge k+n of a frame started at edge k:
  // {BUSY, MDC, MDIO_OE, MDIO_OUT, DATA_RDY}.
  function automatic logic [4:0] model(input int n, input int d, input int p,
                                       input logic [31:0] f);
    int   nend, j, ph, bi;
    logic rd, hi;
    rd   = (f[29:28] == 2'b10);
    nend = 1 + 2 * d * (p + 32);
    if (n < 1) return (n == 0) ? 5'b10000 : 5'b00000;
    if (n >= nend) return {4'b0000, (n == nend) && rd};
    j  = (n - 1) / (2 * d);
    ph = (n - 1) % (2 * d);
    hi = (ph >= d);
    if (j < p) return {1'b1, hi, 1'b1, 1'b1, 1'b0};
    bi = j - p;
    if (rd && bi >= 14) return {1'b1, hi, 1'b0, 1'b0, 1'b0};
    return {1'b1, hi, 1'b1, f[31 - bi], 1'b0};
  endfunction

  function automatic logic [63:0] fld(input int i, input int f);
    case (f)
      F_BUSY:   return 64'(busy_w[i]);
      F_MDC:    return 64'(mdc_w[i]);
      F_OE:     return 64'(oe_w[i]);
      F_OUT:    return 64'(out_w[i]);
      F_RDY:    return 64'(rdy_w[i]);
      F_RD:     return 64'(rd_w[i]);
      F_CAP:    return cap[i];
      F_CAPN:   return 64'(capn[i]);
      F_PER:    return 64'(r2[i] - r1[i]);
      default:  return 64'(rdycnt[i]);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  int          e_v, n_v, j_v;
  logic [4:0]  ex;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        e_v = cyc;
        if (rst_e[i] == e_v) begin
          kk[i]      = -1;
          done_id[i] = req_id[i];
          exp_rd[i]  = 16'h0;
        end
        if (req_id[i] != done_id[i] && e_v >= kp[i]) begin
          done_id[i] = req_id[i];
          kk[i] = kp[i];
          ff[i] = fp[i];
          rr[i] = rp[i];
          cap[i] = 64'h0;
          capn[i] = 0;
          r1[i] = -1;
          r2[i] = -1;
        end
        n_v = (kk[i] >= 0) ? e_v - kk[i] : -1;
        ex  = model(n_v, dv(i), pv(i), ff[i]);
        if (ex[0]) exp_rd[i] = rr[i];
        chk("BUSY",     i, 64'(busy_w[i]), 64'(ex[4]));
        chk("MDC",      i, 64'(mdc_w[i]),  64'(ex[3]));
        chk("MDIO_OE",  i, 64'(oe_w[i]),   64'(ex[2]));
        chk("MDIO_OUT", i, 64'(out_w[i]),  64'(ex[1]));
        chk("DATA_RDY", i, 64'(rdy_w[i]),  64'(ex[0]));
        chk("RD_DATA",  i, 64'(rd_w[i]),   64'(exp_rd[i]));

        if (rdy_w[i]) rdycnt[i]++;
        if (mdc_w[i] && !mdc_prev[i]) begin
          if (oe_w[i]) begin
            cap[i] = {cap[i][62:0], out_w[i]};
            capn[i]++;
          end
          if (r1[i] < 0)      r1[i] = e_v;
          else if (r2[i] < 0) r2[i] = e_v;
        end
        mdc_prev[i] = mdc_w[i];

        // PHY responder: drives data bit i for the whole slot it occupies.
        mdin_s[i] = 1'b1;
        if (n_v >= 1 && ff[i][29:28] == 2'b10) begin
          j_v = (n_v - 1) / (2 * dv(i)) - pv(i);
          if (j_v >= 16 && j_v <= 31) mdin_s[i] = rr[i][31 - j_v];
        end

        for (int q = 0; q < lit_n; q++)
          if (lit_e[q] == e_v && lit_i[q] == i)
            chk(lit_nm[q], i, fld(i, lit_f[q]), lit_v[q]);
      end
    end
  end

  task automatic at_edge(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input int e, input int i, input int f, input logic [63:0] v,
                     input string nm);
    lit_e[lit_n] = e;
    lit_i[lit_n] = i;
    lit_f[lit_n] = f;
    lit_v[lit_n] = v;
    lit_nm[lit_n] = nm;
    lit_n++;
  endtask

  task automatic start(input int i, input logic [31:0] f, input logic [15:0] r,
                       output int k);
    k = cyc + 1;
    td_s[i] = f;
    start_s[i] = 1'b1;
    kp[i] = k;
    fp[i] = f;
    rp[i] = r;
    req_id[i]++;
    at_edge(k);
    start_s[i] = 1'b0;
  endtask

  int k, k2;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1;
      start_s[i] = 1'b0;
      td_s[i] = 32'h0;
    end
    at_edge(1);
    chk_on = 1'b1;
    lit(2, 0, F_BUSY, 64'h0, "reset_busy");
    lit(2, 0, F_RD,   64'h0, "reset_rd");
    lit(2, 1, F_MDC,  64'h0, "reset_mdc");
    at_edge(2);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    // Write 0x52515555, no preamble.
    start(0, 32'h52515555, 16'h0, k);
    lit(k + 64, 0, F_BUSY, 64'h1,        "wr_busy_k64");
    lit(k + 65, 0, F_BUSY, 64'h0,        "wr_busy_k65");
    lit(k + 65, 0, F_CAP,  64'h52515555, "wr_bits");
    lit(k + 65, 0, F_CAPN, 64'd32,       "wr_nbits");
    at_edge(k + 70);

    // Read 0x64A00000, responder returns 0xAAAA.
    start(0, 32'h64A00000, 16'hAAAA, k);
    lit(k + 28, 0, F_OE,   64'h1,    "rd_oe_k28");
    lit(k + 29, 0, F_OE,   64'h0,    "rd_oe_k29");
    lit(k + 64, 0, F_RDY,  64'h0,    "rd_rdy_k64");
    lit(k + 65, 0, F_RDY,  64'h1,    "rd_rdy_k65");
    lit(k + 66, 0, F_RDY,  64'h0,    "rd_rdy_k66");
    lit(k + 65, 0, F_RD,   64'hAAAA, "rd_data");
    lit(k + 65, 0, F_CAP,  64'h1928, "rd_addr_bits");
    lit(k + 65, 0, F_CAPN, 64'd14,   "rd_nbits");
    at_edge(k + 70);

    // OP=11 write with ignored starts at k+10 and k+64/k+65, accepted at k+66.
    start(0, 32'h7FFFFFFF, 16'h0, k);
    lit(k + 65, 0, F_CAP,  64'h7FFFFFFF, "op11_bits");
    lit(k + 65, 0, F_CAPN, 64'd32,       "op11_nbits");
    lit(k + 65, 0, F_BUSY, 64'h0,        "op11_busy_k65");
    at_edge(k + 9);
    start_s[0] = 1'b1;
    at_edge(k + 10);
    start_s[0] = 1'b0;
    at_edge(k + 63);
    td_s[0] = 32'h52515555;
    start_s[0] = 1'b1;
    k2 = k + 66;
    kp[0] = k2;
    fp[0] = 32'h52515555;
    rp[0] = 16'h0;
    req_id[0]++;
    at_edge(k2);
    start_s[0] = 1'b0;
    lit(k2 + 1,  0, F_BUSY, 64'h1,        "restart_busy");
    lit(k2 + 1,  0, F_MDC,  64'h0,        "restart_mdc_low");
    lit(k2 + 2,  0, F_MDC,  64'h1,        "restart_mdc_high");
    lit(k2 + 65, 0, F_CAP,  64'h52515555, "restart_bits");
    at_edge(k2 + 70);

    // Reset held two cycles mid-write, then a fresh read.
    start(0, 32'h52515555, 16'h0, k);
    at_edge(k + 20);
    rst_s[0] = 1'b1;
    rst_e[0] = k + 21;
    lit(k + 21, 0, F_BUSY, 64'h0, "rst_busy");
    lit(k + 21, 0, F_MDC,  64'h0, "rst_mdc");
    lit(k + 21, 0, F_OE,   64'h0, "rst_oe");
    lit(k + 21, 0, F_RD,   64'h0, "rst_rd");
    at_edge(k + 22);
    rst_s[0] = 1'b0;
    at_edge(k + 24);
    start(0, 32'h64A00000, 16'h1234, k);
    lit(k + 65, 0, F_RD,  64'h1234, "post_rst_rd");
    lit(k + 65, 0, F_RDY, 64'h1,    "post_rst_rdy");
    at_edge(k + 70);

    // Preamble 32, DIV_HALF 2, read returning 0x1234.
    start(1, 32'h64A01234, 16'h1234, k);
    lit(k + 2,   1, F_MDC,  64'h0,               "pre_mdc_k2");
    lit(k + 3,   1, F_MDC,  64'h1,               "pre_mdc_k3");
    lit(k + 184, 1, F_OE,   64'h1,               "pre_oe_k184");
    lit(k + 185, 1, F_OE,   64'h0,               "pre_oe_k185");
    lit(k + 257, 1, F_RD,   64'h1234,            "pre_rd_data");
    lit(k + 257, 1, F_RDY,  64'h1,               "pre_rdy");
    lit(k + 257, 1, F_CAP,  64'h3FFF_FFFF_D928,  "pre_bits");
    lit(k + 257, 1, F_CAPN, 64'd46,              "pre_nbits");
    lit(k + 257, 1, F_PER,  64'd4,               "pre_mdc_period");
    lit(k + 260, 0, F_RDYCNT, 64'd2,             "rdy_count_a");
    lit(k + 260, 1, F_RDYCNT, 64'd1,             "rdy_count_b");
    at_edge(k + 262);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
